// File: rtl/decoder_fec_pkg.sv
// Shared types and constants for the SECDED receive-side decoder.
package decoder_fec_pkg;

    localparam int FEC_DATA_WIDTH     = 32;
    localparam int CODEWORDS_PER_WORD = FEC_DATA_WIDTH / 8;

    typedef logic [7:0] fec_codeword_t;
    typedef logic [3:0] fec_nibble_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WAIT_EMPTY,
        ST_WRITE
    } dec_state_t;

    function automatic logic [2:0] countOnes4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/decoder_fec_hamming84_dec.sv
// Combinational extended Hamming(8,4) decoder: bit 0 is overall parity, bits 1..7 are Hamming positions.
module hamming84_dec
    import decoder_fec_pkg::*;
(
    input  fec_codeword_t i_codeword,
    output fec_nibble_t   o_nibble,
    output logic          o_corrected,
    output logic          o_uncorrectable
);

    logic [2:0]    w_syn;
    logic          w_par;
    fec_codeword_t w_fixed;

    // A syndrome of zero with odd parity means the parity bit itself flipped, so bit 0 is the target.
    always_comb begin
        w_syn = {^{i_codeword[4], i_codeword[5], i_codeword[6], i_codeword[7]},
                 ^{i_codeword[2], i_codeword[3], i_codeword[6], i_codeword[7]},
                 ^{i_codeword[1], i_codeword[3], i_codeword[5], i_codeword[7]}};
        w_par   = ^i_codeword;
        w_fixed = i_codeword;
        if (w_par) begin
            w_fixed[w_syn] = ~i_codeword[w_syn];
        end
        o_nibble        = {w_fixed[7], w_fixed[6], w_fixed[5], w_fixed[3]};
        o_corrected     = w_par;
        o_uncorrectable = !w_par && (w_syn != 3'd0);
    end

endmodule

// File: rtl/decoder_fec.sv
// SECDED receive decoder: reads two encoded words, decodes 8 codewords into one 32-bit message.
// Optional DECODER_FEC_DROP_UNCORR_EN discards messages containing any uncorrectable codeword.
module decoder_fec
    import decoder_fec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  in_rd_en,
    input  logic [DATA_WIDTH-1:0] in_rd_data,
    input  logic                  in_empty,
    input  logic                  in_rd_valid,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    input  logic                  out_full,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt,
    output logic                  busy
);

    localparam int HALF_WIDTH = DATA_WIDTH / 2;

    dec_state_t                    r_state;
    dec_state_t                    w_stateNext;
    logic                          r_highHalf;
    logic [HALF_WIDTH-1:0]         r_lowHalf;
    logic [DATA_WIDTH-1:0]         r_msg;
    logic [CNT_WIDTH-1:0]          r_corrCnt;
    logic [CNT_WIDTH-1:0]          r_uncorrCnt;
    logic [HALF_WIDTH-1:0]         w_half;
    logic [CODEWORDS_PER_WORD-1:0] w_corrVec;
    logic [CODEWORDS_PER_WORD-1:0] w_uncorrVec;
    logic [2:0]                    w_corrInc;
    logic [2:0]                    w_uncorrInc;
    logic [CNT_WIDTH:0]            w_corrSum;
    logic [CNT_WIDTH:0]            w_uncorrSum;
    logic                          w_beat;
    logic                          w_dropMsg;

    for (genvar k = 0; k < CODEWORDS_PER_WORD; k++) begin : g_dec
        hamming84_dec u_dec (
            .i_codeword      (in_rd_data[8*k +: 8]),
            .o_nibble        (w_half[4*k +: 4]),
            .o_corrected     (w_corrVec[k]),
            .o_uncorrectable (w_uncorrVec[k])
        );
    end

    assign w_beat      = (r_state == ST_WAIT) && in_rd_valid;
    assign w_corrInc   = countOnes4(w_corrVec);
    assign w_uncorrInc = countOnes4(w_uncorrVec);
    assign w_corrSum   = {1'b0, r_corrCnt} + {{(CNT_WIDTH-2){1'b0}}, w_corrInc};
    assign w_uncorrSum = {1'b0, r_uncorrCnt} + {{(CNT_WIDTH-2){1'b0}}, w_uncorrInc};

`ifdef DECODER_FEC_DROP_UNCORR_EN
    logic r_lowUncorr;
    assign w_dropMsg = r_lowUncorr || (|w_uncorrVec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lowUncorr <= 1'b0;
        end else if (w_beat && !r_highHalf) begin
            r_lowUncorr <= |w_uncorrVec;
        end
    end
`else
    assign w_dropMsg = 1'b0;
`endif

    always_comb begin
        w_stateNext = r_state;
        in_rd_en    = 1'b0;
        out_wr_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && !in_empty) w_stateNext = ST_REQ;
            end
            ST_REQ: begin
                if (!in_empty) begin
                    in_rd_en    = 1'b1;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (in_rd_valid) begin
                    if (!r_highHalf)
                        w_stateNext = in_empty ? ST_WAIT_EMPTY : ST_REQ;
                    else if (w_dropMsg)
                        w_stateNext = (en && !in_empty) ? ST_REQ : ST_IDLE;
                    else
                        w_stateNext = ST_WRITE;
                end
            end
            ST_WAIT_EMPTY: begin
                if (!in_empty) w_stateNext = ST_REQ;
            end
            ST_WRITE: begin
                if (!out_full) begin
                    out_wr_en   = 1'b1;
                    w_stateNext = (en && !in_empty) ? ST_REQ : ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Counters saturate via the carry-out of a one-bit-wider sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_highHalf  <= 1'b0;
            r_lowHalf   <= '0;
            r_msg       <= '0;
            r_corrCnt   <= '0;
            r_uncorrCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_beat) begin
                r_corrCnt   <= w_corrSum[CNT_WIDTH]   ? '1 : w_corrSum[CNT_WIDTH-1:0];
                r_uncorrCnt <= w_uncorrSum[CNT_WIDTH] ? '1 : w_uncorrSum[CNT_WIDTH-1:0];
                if (!r_highHalf) begin
                    r_lowHalf  <= w_half;
                    r_highHalf <= 1'b1;
                end else begin
                    r_highHalf <= 1'b0;
                    r_msg      <= {w_half, r_lowHalf};
                end
            end
        end
    end

    assign out_wr_data = r_msg;
    assign corr_cnt    = r_corrCnt;
    assign uncorr_cnt  = r_uncorrCnt;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_decoder_fec.sv
// Directed-vector bench for decoder_fec with an upstream FIFO model and a downstream write monitor.
module tb_decoder_fec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_rd_en;
    logic [31:0] in_rd_data;
    logic        in_empty;
    logic        in_rd_valid;
    logic        out_wr_en;
    logic [31:0] out_wr_data;
    logic        out_full = 1'b0;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        busy;

    logic [31:0] inQ[$];
    logic [31:0] outQ[$];
    int          pushCount = 0;
    int          popCount = 0;
    int          writeCount = 0;
    int          rdPulses = 0;
    int          rdWhileEmpty = 0;
    int          wrWhileFull = 0;
    logic [31:0] lastWr = '0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign in_empty = (pushCount == popCount);

    decoder_fec #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_rd_en    (in_rd_en),
        .in_rd_data  (in_rd_data),
        .in_empty    (in_empty),
        .in_rd_valid (in_rd_valid),
        .out_wr_en   (out_wr_en),
        .out_wr_data (out_wr_data),
        .out_full    (out_full),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt),
        .busy        (busy)
    );

    // Upstream buffer returns data one cycle after the read strobe; writes are logged downstream.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_rd_valid <= 1'b0;
            in_rd_data  <= '0;
        end else begin
            in_rd_valid <= 1'b0;
            if (in_rd_en) begin
                rdPulses <= rdPulses + 1;
                if (in_empty) rdWhileEmpty <= rdWhileEmpty + 1;
                if (inQ.size() > 0) begin
                    in_rd_valid <= 1'b1;
                    in_rd_data  <= inQ.pop_front();
                    popCount    <= popCount + 1;
                end
            end
            if (out_wr_en) begin
                if (out_full) wrWhileFull <= wrWhileFull + 1;
                writeCount <= writeCount + 1;
                lastWr     <= out_wr_data;
                outQ.push_back(out_wr_data);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushWord(input logic [31:0] w);
        inQ.push_back(w);
        pushCount++;
    endtask

    task automatic waitWrites(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (writeCount >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitPops(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (popCount >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        vectors++;
        if ({in_rd_en, out_wr_en, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL %s_strobes: got rd/wr/busy=%b expected 000", tag, {in_rd_en, out_wr_en, busy});
        end
        vectors++;
        if (out_wr_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL %s_data: got %h expected 00000000", tag, out_wr_data);
        end
        vectors++;
        if ({corr_cnt, uncorr_cnt} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL %s_counts: got corr=%0d uncorr=%0d expected 0/0", tag, corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic checkMessage(input string tag, input logic [31:0] expData, input int expWrites,
                                input logic [15:0] expCorr, input logic [15:0] expUncorr);
        bit ok;
        waitWrites(expWrites, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got writes=%0d expected %0d", tag, writeCount, expWrites);
        end
        cycles(4);
        vectors++;
        if (lastWr !== expData) begin
            miscompares++;
            $display("[TB] FAIL %s_data: got %h expected %h", tag, lastWr, expData);
        end
        vectors++;
        if (writeCount !== expWrites) begin
            miscompares++;
            $display("[TB] FAIL %s_count: got writes=%0d expected %0d", tag, writeCount, expWrites);
        end
        vectors++;
        if (corr_cnt !== expCorr || uncorr_cnt !== expUncorr) begin
            miscompares++;
            $display("[TB] FAIL %s_counters: got corr=%0d uncorr=%0d expected %0d/%0d",
                     tag, corr_cnt, uncorr_cnt, expCorr, expUncorr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(2);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        cycles(1);
    endtask

    task automatic test_clean();
        pushWord(32'hA5A5A5A5);
        pushWord(32'h00000000);
        checkMessage("clean", 32'h0000AAAA, writeCount + 1, 16'd0, 16'd0);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clean_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single_error();
        pushWord(32'hA5A5A5E5);
        pushWord(32'hA5A5A5A5);
        checkMessage("single", 32'hAAAAAAAA, writeCount + 1, 16'd1, 16'd0);
    endtask

    task automatic test_double_error();
        int base = writeCount;
        pushWord(32'hA5A5A5A6);
        pushWord(32'hA5A5A5A5);
`ifdef DECODER_FEC_DROP_UNCORR_EN
        cycles(30);
        vectors++;
        if (writeCount !== base || popCount !== pushCount || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL double_drop: got writes=%0d pops=%0d busy=%b expected %0d/%0d/0",
                     writeCount, popCount, busy, base, pushCount);
        end
        vectors++;
        if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL double_counters: got corr=%0d uncorr=%0d expected 1/1", corr_cnt, uncorr_cnt);
        end
`else
        checkMessage("double", 32'hAAAAAAAA, base + 1, 16'd1, 16'd1);
`endif
    endtask

    task automatic test_mixed_and_parity_bit();
        int base = writeCount;
        pushWord(32'hA6E500A5);
        pushWord(32'hA4A4A4A4);
`ifdef DECODER_FEC_DROP_UNCORR_EN
        cycles(30);
        vectors++;
        if (writeCount !== base || corr_cnt !== 16'd6 || uncorr_cnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL mixed_drop: got writes=%0d corr=%0d uncorr=%0d expected %0d/6/2",
                     writeCount, corr_cnt, uncorr_cnt, base);
        end
`else
        checkMessage("mixed", 32'hAAAAAA0A, base + 1, 16'd6, 16'd2);
`endif
    endtask

    task automatic test_back_to_back();
        int  base = writeCount;
        bit  ok;
        outQ.delete();
        pushWord(32'hA5A5A5A5);
        pushWord(32'hA5A5A5A5);
        pushWord(32'h00000000);
        pushWord(32'hA5A5A5A5);
        waitWrites(base + 2, 12, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL b2b_throughput: got writes=%0d within 12 cycles expected %0d", writeCount, base + 2);
        end
        cycles(3);
        vectors++;
        if (outQ.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d writes expected 2", outQ.size());
        end else begin
            vectors++;
            if (outQ[0] !== 32'hAAAAAAAA || outQ[1] !== 32'hAAAA0000) begin
                miscompares++;
                $display("[TB] FAIL b2b_data: got %h,%h expected aaaaaaaa,aaaa0000", outQ[0], outQ[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base    = writeCount;
        int basePop = popCount;
        bit ok;
        outQ.delete();
        out_full = 1'b1;
        pushWord(32'h00A500A5);
        pushWord(32'hA5A5A500);
        pushWord(32'hA5A5A5A5);
        pushWord(32'hA5A5A5A5);
        waitPops(basePop + 2, 20, ok);
        cycles(2);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_wr_data !== 32'hAAA00A0A || out_wr_en !== 1'b0 || in_rd_en !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got data=%h wr=%b rd=%b expected aaa00a0a/0/0",
                         i, out_wr_data, out_wr_en, in_rd_en);
            end
            cycles(1);
        end
        vectors++;
        if (writeCount !== base || popCount !== basePop + 2) begin
            miscompares++;
            $display("[TB] FAIL bp_stall: got writes=%0d pops=%0d expected %0d/%0d",
                     writeCount, popCount, base, basePop + 2);
        end
        out_full = 1'b0;
        waitWrites(base + 2, 30, ok);
        cycles(3);
        vectors++;
        if (outQ.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d writes expected 2", outQ.size());
        end else begin
            vectors++;
            if (outQ[0] !== 32'hAAA00A0A || outQ[1] !== 32'hAAAAAAAA) begin
                miscompares++;
                $display("[TB] FAIL bp_data: got %h,%h expected aaa00a0a,aaaaaaaa", outQ[0], outQ[1]);
            end
        end
    endtask

    task automatic test_empty_gap();
        int base = writeCount;
        int pulses;
        bit ok;
        pushWord(32'h0000A5A5);
        waitPops(popCount + 1, 20, ok);
        cycles(1);
        pulses = rdPulses;
        cycles(20);
        vectors++;
        if (rdPulses !== pulses || busy !== 1'b1 || writeCount !== base) begin
            miscompares++;
            $display("[TB] FAIL gap_hold: got rd_pulses=%0d busy=%b writes=%0d expected %0d/1/%0d",
                     rdPulses, busy, writeCount, pulses, base);
        end
        pushWord(32'hA5000000);
        checkMessage("gap", 32'hA00000AA, base + 1, corr_cnt, uncorr_cnt);
    endtask

    task automatic test_reset_mid_message();
        bit ok;
        pushWord(32'h000000A5);
        waitPops(popCount + 1, 20, ok);
        cycles(1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        pushWord(32'hA5A5A5A5);
        pushWord(32'h00000000);
        checkMessage("midreset_fresh", 32'h0000AAAA, writeCount + 1, 16'd0, 16'd0);
    endtask

    task automatic test_saturation();
        int base = writeCount;
        bit ok;
        outQ.delete();
        for (int i = 0; i < 16400; i++) pushWord(32'hA4A4A4A4);
        waitWrites(base + 8200, 45000, ok);
        cycles(4);
        vectors++;
        if (!ok || writeCount !== base + 8200) begin
            miscompares++;
            $display("[TB] FAIL sat_writes: got %0d expected %0d", writeCount, base + 8200);
        end
        vectors++;
        if (corr_cnt !== 16'hFFFF || uncorr_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL sat_counters: got corr=%0d uncorr=%0d expected 65535/0", corr_cnt, uncorr_cnt);
        end
        vectors++;
        if (lastWr !== 32'hAAAAAAAA) begin
            miscompares++;
            $display("[TB] FAIL sat_data: got %h expected aaaaaaaa", lastWr);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_double_error();
        test_mixed_and_parity_bit();
        test_back_to_back();
        test_backpressure();
        test_empty_gap();
        test_reset_mid_message();
        test_saturation();
        vectors++;
        if (rdWhileEmpty !== 0 || wrWhileFull !== 0) begin
            miscompares++;
            $display("[TB] FAIL protocol: got rd_while_empty=%0d wr_while_full=%0d expected 0/0",
                     rdWhileEmpty, wrWhileFull);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_fec.md
Name: decoder_fec

Overview:
- Receive-side counterpart of the FEC encoder path.
- Pops demodulated 32-bit words from the upstream receive buffer and decodes each byte as an extended Hamming(8,4) SECDED codeword, giving 4 data bits per codeword.
- Pairs two decoded 16-bit halves into one 32-bit message word and pushes it into the downstream message buffer.
- Keeps saturating counts of corrected and uncorrectable codewords.

Parameters:
- DATA_WIDTH, 32, width of encoded, demodulated and message words; fixed at 32 by the codeword packing.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable
- in_rd_en  out  1  one-cycle read request to upstream buffer
- in_rd_data  in  DATA_WIDTH  demodulated word (demodulated_message_data_t)
- in_empty  in  1  upstream buffer empty
- in_rd_valid  in  1  in_rd_data valid this cycle
- out_wr_en  out  1  write strobe to downstream buffer
- out_wr_data  out  DATA_WIDTH  decoded message (message_data_t)
- out_full  in  1  downstream buffer full
- corr_cnt  out  CNT_WIDTH  corrected codewords, saturating
- uncorr_cnt  out  CNT_WIDTH  uncorrectable codewords, saturating
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, partial half discarded. Reset mid-message drops the pending low half; nothing is written.
- Codeword layout (one byte):
  - Bit 0 = overall even parity p0. Bits 1..7 = Hamming positions 1..7.
  - p1 = bit1, p2 = bit2, d0 = bit3, p4 = bit4, d1 = bit5, d2 = bit6, d3 = bit7.
- Decode:
  - s1 = ^{b1,b3,b5,b7}; s2 = ^{b2,b3,b6,b7}; s4 = ^{b4,b5,b6,b7}; s = {s4,s2,s1}; P = ^b[7:0].
  - s=0, P=0: clean.
  - P=1: single error. Flip bit s (bit 0 when s=0), count as corrected.
  - s!=0, P=0: uncorrectable. Pass raw d bits, count as uncorrectable.
- Packing: byte k of an encoded word gives nibble k. The first word read gives message[15:0], the second gives message[31:16].
- FSM:
  - IDLE → REQ when en=1 and in_empty=0.
  - REQ: in_rd_en=1 for exactly one cycle → WAIT.
  - WAIT: hold until in_rd_valid. No timeout; upstream latency ≥1 cycle, any length.
    - Decode and latch the half.
    - If this was the low half: → REQ when in_empty=0, else stay in WAIT_EMPTY.
    - If this was the high half: → WRITE.
  - WAIT_EMPTY: → REQ when in_empty=0.
  - WRITE: when out_full=0, assert out_wr_en for 1 cycle with out_wr_data → IDLE (or REQ if en=1 and in_empty=0). While out_full=1, hold out_wr_data stable.
- Never issue in_rd_en while in_empty=1. At most one outstanding read.
- en=0 mid-message: finish the current message, then IDLE.
- in_rd_valid outside WAIT is ignored.
- Counters:
  - Up to 4 increments per word, added in one cycle on the valid beat.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - A word with mixed corrected and uncorrectable bytes updates both counters.
- Throughput: one message per ≥5 cycles with 1-cycle upstream latency.

Optional Feature:
- DECODER_FEC_DROP_UNCORR_EN defined:
  - A message with any uncorrectable codeword in either half is discarded; no out_wr_en is issued.
  - uncorr_cnt still increments.
  - The FSM returns from the high-half WAIT directly to IDLE/REQ.
- Not defined: the message is always written, with raw data in the uncorrectable nibbles.

Decomposition:
- encoder_fec_pkg gains:
  - typedef logic[7:0] fec_codeword_t
  - typedef logic[3:0] fec_nibble_t
  - typedef enum for FSM states
  - localparam CODEWORDS_PER_WORD = DATA_WIDTH/8
- Sub-module hamming84_dec (combinational):
  - In: codeword.
  - Out: nibble, corrected, uncorrectable.
  - Instantiated 4× in decoder_fec.

Test Plan:
- Clean pair: in words 0xA5A5A5A5 then 0x00000000 → one write out_wr_data=0x0000AAAA; corr_cnt=0, uncorr_cnt=0.
- Single error: first word 0xA5A5A5E5 (bit 6 flipped), second 0xA5A5A5A5 → out 0xAAAAAAAA; corr_cnt=1.
- Double error: first word 0xA5A5A5A6 (bits 0,1 flipped) → uncorr_cnt=1.
  - Without the macro: out 0x????AAAA with raw nibble 0xA.
  - With DECODER_FEC_DROP_UNCORR_EN: no out_wr_en for that pair.
- Backpressure: hold out_full=1 for 10 cycles in WRITE → out_wr_data stable, out_wr_en=0 and in_rd_en=0 throughout; a single write follows release.
- Empty gap: in_empty=1 after the low half for 20 cycles → no in_rd_en. Refill → high half read, message written once.
- Reset mid-message: assert rst_n=0 after the low half → all outputs 0 immediately. The next two words form a fresh message; the first half is not reused.
